// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO responder.
//   Register offsets inside the 6-byte window, TCTRL/STATUS bit positions,
//   and a helper that assembles the STATUS byte.
package mmio_pkg;

  localparam logic [2:0] OFF_LED    = 3'd0;
  localparam logic [2:0] OFF_SW     = 3'd1;
  localparam logic [2:0] OFF_TCNT   = 3'd2;
  localparam logic [2:0] OFF_TCTRL  = 3'd3;
  localparam logic [2:0] OFF_TXDATA = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd5;

  localparam int TCTRL_EN_BIT   = 0;
  localparam int TCTRL_WRAP_BIT = 1;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_OVF_BIT   = 5;

  function automatic logic [7:0] pack_status(input logic       ovf,
                                             input logic [2:0] count,
                                             input logic       full,
                                             input logic       empty);
    logic [7:0] s;
    s = '0;
    s[STATUS_OVF_BIT]                        = ovf;
    s[STATUS_COUNT_LSB+2:STATUS_COUNT_LSB]   = count;
    s[STATUS_FULL_BIT]                       = full;
    s[STATUS_EMPTY_BIT]                      = empty;
    return s;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with head-of-queue output.
//   clock, reset     : clock, async active-high reset (pointers/count only)
//   push, push_data  : enqueue request; accepted when not full or when a
//                      pop happens in the same cycle
//   pop              : dequeue request; ignored when empty
//   full, empty      : occupancy flags
//   count            : entries held, 0..DEPTH
//   head             : oldest entry (undefined content when empty)
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O block on the 8-bit data-memory port.
//   clock, reset        : processor clock, async active-high reset
//   MemRead, wren       : data-port read / write strobes
//   address, data       : data-port address and write data
//   q, io_hit           : registered read data and "q is I/O data" flag
//   sw_in               : asynchronous switches (2-flop synchronized)
//   led_out             : LED register
//   tx_data, tx_valid   : TX FIFO head and non-empty flag
//   tx_ready            : consumer takes the head this cycle
// Window BASE_ADDR..BASE_ADDR+5: LED, SW, TCNT, TCTRL, TXDATA, STATUS.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter int         FIFO_DEPTH = 4,
  parameter int         PRESCALE   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       wren,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic [7:0] q,
  output logic       io_hit,
  input  logic [7:0] sw_in,
  output logic [7:0] led_out,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int         CW         = $clog2(FIFO_DEPTH+1);
  localparam logic [7:0] LAST_ADDR  = BASE_ADDR + 8'd5;
  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  logic       sel;
  logic [2:0] offset;
  logic       wr_en, rd_en;
  logic       wr_led, wr_tcnt, wr_tctrl, wr_txdata, wr_status;

  logic [7:0] sw_meta, sw_sync;
  logic [7:0] tcnt, presc;
  logic       tctrl_en, tctrl_wrap;
  logic       tick, wrap_set;
  logic       overflow;

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic [2:0]    count3;
  logic [7:0]    rd_data;

  // Window is 8-aligned, so the low address bits are the register offset.
  assign sel    = (address >= BASE_ADDR) && (address <= LAST_ADDR);
  assign offset = address[2:0];
  assign wr_en  = wren && sel;
  // A simultaneous write wins; the read is dropped.
  assign rd_en  = MemRead && sel && !wren;

  assign wr_led    = wr_en && (offset == OFF_LED);
  assign wr_tcnt   = wr_en && (offset == OFF_TCNT);
  assign wr_tctrl  = wr_en && (offset == OFF_TCTRL);
  assign wr_txdata = wr_en && (offset == OFF_TXDATA);
  assign wr_status = wr_en && (offset == OFF_STATUS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) led_out <= '0;
    else if (wr_led) led_out <= data;
  end

  // Timer: prescaler counts 0..PRESCALE-1, TCNT advances on its last value.
  assign tick     = tctrl_en && (presc == PRESC_LAST);
  assign wrap_set = tick && (tcnt == 8'hFF) && !wr_tcnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      presc <= '0;
    end else if (wr_tcnt) begin
      tcnt  <= '0;
      presc <= '0;
    end else if (tctrl_en) begin
      if (tick) begin
        presc <= '0;
        tcnt  <= tcnt + 8'd1;
      end else begin
        presc <= presc + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tctrl_en   <= 1'b0;
      tctrl_wrap <= 1'b0;
    end else begin
      if (wr_tctrl) tctrl_en <= data[TCTRL_EN_BIT];
      // Wrap set beats a same-cycle write-1-to-clear.
      if (wrap_set)
        tctrl_wrap <= 1'b1;
      else if (wr_tctrl && data[TCTRL_WRAP_BIT])
        tctrl_wrap <= 1'b0;
    end
  end

  assign fifo_pop = tx_ready && !fifo_empty;

  io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_txdata),
    .push_data (data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (wr_txdata && fifo_full && !fifo_pop) overflow <= 1'b1;
    else if (wr_status) overflow <= 1'b0;
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_head;
  assign count3   = 3'(fifo_count);

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      OFF_LED:    rd_data = led_out;
      OFF_SW:     rd_data = sw_sync;
      OFF_TCNT:   rd_data = tcnt;
      OFF_TCTRL:  rd_data = {6'b0, tctrl_wrap, tctrl_en};
      OFF_TXDATA: rd_data = tx_data;
      OFF_STATUS: rd_data = pack_status(overflow, count3, fifo_full, fifo_empty);
      default:    rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q      <= '0;
      io_hit <= 1'b0;
    end else if (rd_en) begin
      q      <= rd_data;
      io_hit <= 1'b1;
    end else begin
      io_hit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

  localparam logic [7:0] BASE  = 8'hF0;
  localparam int         DEPTH = 4;
  localparam int         PRESC = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       MemRead, wren, tx_ready;
  logic [7:0] address, data, sw_in;
  logic [7:0] q, led_out, tx_data;
  logic       io_hit, tx_valid;

  mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PRESCALE(PRESC)) dut (
    .clock    (clock),
    .reset    (reset),
    .MemRead  (MemRead),
    .wren     (wren),
    .address  (address),
    .data     (data),
    .q        (q),
    .io_hit   (io_hit),
    .sw_in    (sw_in),
    .led_out  (led_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: register values, a byte queue for the FIFO,
  // integer timer counts.
  logic [7:0] m_led, m_q, m_sw1, m_sw2;
  bit         m_hit, m_en, m_wrap, m_ovf;
  int         m_tcnt, m_presc;
  logic [7:0] fq[$];

  function automatic logic [7:0] model_read(input int off);
    case (off)
      0:       return m_led;
      1:       return m_sw2;
      2:       return 8'(m_tcnt);
      3:       return {6'b0, m_wrap, m_en};
      4:       return (fq.size() > 0) ? fq[0] : 8'h00;
      5:       return {2'b0, m_ovf, 3'(fq.size()), fq.size() == DEPTH, fq.size() == 0};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_led = 0; m_q = 0; m_sw1 = 0; m_sw2 = 0;
    m_hit = 0; m_en = 0; m_wrap = 0; m_ovf = 0;
    m_tcnt = 0; m_presc = 0;
    fq.delete();
  endtask

  task automatic model_step();
    bit         sel, wr, rd, pop, wrap_set;
    int         off, sz;
    logic [7:0] rv;
    sel      = (address >= BASE) && (int'(address) <= int'(BASE) + 5);
    off      = int'(address) - int'(BASE);
    wr       = wren && sel;
    rd       = MemRead && sel && !wren;
    rv       = model_read(off);
    sz       = fq.size();
    pop      = (sz > 0) && tx_ready;
    wrap_set = 0;
    if (wr && off == 2) begin
      m_tcnt = 0; m_presc = 0;
    end else if (m_en) begin
      m_presc++;
      if (m_presc == PRESC) begin
        m_presc = 0;
        m_tcnt  = (m_tcnt + 1) % 256;
        if (m_tcnt == 0) wrap_set = 1;
      end
    end
    if (wr && off == 3) begin
      if (data[1]) m_wrap = 0;
      m_en = data[0];
    end
    if (wrap_set) m_wrap = 1;
    if (wr && off == 0) m_led = data;
    if (wr && off == 5) m_ovf = 0;
    if (pop) void'(fq.pop_front());
    if (wr && off == 4) begin
      if (sz < DEPTH || pop) fq.push_back(data);
      else m_ovf = 1;
    end
    if (rd) begin m_q = rv; m_hit = 1; end
    else m_hit = 0;
    m_sw2 = m_sw1;
    m_sw1 = sw_in;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ":q"}, q, m_q);
    check_val({tag, ":io_hit"}, io_hit, m_hit);
    check_val({tag, ":led"}, led_out, m_led);
    check_val({tag, ":tx_valid"}, tx_valid, fq.size() > 0);
    check_val({tag, ":tx_data"}, tx_data, (fq.size() > 0) ? fq[0] : 8'h00);
  endtask

  task automatic step(input string tag = "cyc");
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input string tag);
    MemRead = rd; wren = wr; address = a; data = d;
    step(tag);
    MemRead = 0; wren = 0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    bus(1'b0, 1'b1, a, d, "wr");
  endtask

  task automatic read_reg(input logic [7:0] a);
    bus(1'b1, 1'b0, a, 8'h00, "rd");
  endtask

  logic [7:0] seq_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] seq_b [4] = '{8'hBB, 8'hCC, 8'hDD, 8'h66};

  initial begin
    reset = 1; MemRead = 0; wren = 0; address = 0; data = 0; sw_in = 0; tx_ready = 0;
    model_reset();
    #12;
    compare_all("reset");
    check_val("reset_q", q, 8'h00);
    @(negedge clock);
    reset = 0;

    write_reg(8'hF0, 8'hA5);
    check_val("led_a5", led_out, 8'hA5);
    read_reg(8'hF0);
    check_val("rd_led_q", q, 8'hA5);
    check_val("rd_led_hit", io_hit, 1'b1);

    sw_in = 8'h3C;
    step(); step();
    read_reg(8'hF1);
    check_val("rd_sw", q, 8'h3C);
    read_reg(8'h20);
    check_val("outside_hit", io_hit, 1'b0);
    check_val("outside_q", q, 8'h3C);

    write_reg(8'hF3, 8'h01);
    repeat (256) step();
    read_reg(8'hF2);
    check_val("tcnt_wrapped", q, 8'h00);
    read_reg(8'hF3);
    check_val("tctrl_wrap", q, 8'h03);
    write_reg(8'hF3, 8'h03);
    read_reg(8'hF3);
    check_val("tctrl_cleared", q, 8'h01);
    repeat (5) step();
    read_reg(8'hF2);
    write_reg(8'hF2, 8'h77);
    read_reg(8'hF2);
    check_val("tcnt_cleared", q, 8'h00);

    tx_ready = 0;
    foreach (seq_a[i]) write_reg(8'hF4, seq_a[i]);
    write_reg(8'hF4, 8'h55);
    read_reg(8'hF5);
    check_val("status_full_ovf", q, 8'h32);
    read_reg(8'hF4);
    check_val("txdata_peek", q, 8'h11);
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_a", tx_data, seq_a[i]);
      step();
    end
    check_val("drained_valid", tx_valid, 1'b0);
    read_reg(8'hF5);
    check_val("status_empty_ovf", q, 8'h21);
    write_reg(8'hF5, 8'h00);
    read_reg(8'hF5);
    check_val("status_ovf_clr", q, 8'h01);

    tx_ready = 0;
    write_reg(8'hF4, 8'hAA); write_reg(8'hF4, 8'hBB);
    write_reg(8'hF4, 8'hCC); write_reg(8'hF4, 8'hDD);
    tx_ready = 1;
    write_reg(8'hF4, 8'h66);
    tx_ready = 0;
    read_reg(8'hF5);
    check_val("status_push_pop_full", q, 8'h12);
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_b", tx_data, seq_b[i]);
      step();
    end
    check_val("drained_b_valid", tx_valid, 1'b0);

    write_reg(8'hF0, 8'h5A);
    tx_ready = 0;
    for (int i = 1; i <= 4; i++) write_reg(8'hF4, 8'(i));
    tx_ready = 1;
    step();
    #2;
    reset = 1;
    #1;
    model_reset();
    compare_all("rst_mid");
    check_val("rst_mid_valid", tx_valid, 1'b0);
    check_val("rst_mid_led", led_out, 8'h00);
    @(negedge clock);
    reset = 0;
    tx_ready = 0;
    read_reg(8'hF5);
    check_val("rst_mid_status", q, 8'h01);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r        = $urandom_range(0, 9);
      MemRead  = (r < 4) || (r == 9);
      wren     = (r >= 4 && r < 8) || (r == 9);
      address  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 7));
      data     = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) sw_in = 8'($urandom);
      step("rand");
    end
    MemRead = 0; wren = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the processor's 8-bit data-memory port (MemRead/wren/address/data/q).
- Claims the address window BASE_ADDR..BASE_ADDR+5 and asserts io_hit.
- The top level steers q from this block instead of data RAM when io_hit is set.
- Provides an LED register, synchronized switch input, a prescaled 8-bit timer, and a transmit FIFO drained by an external consumer over a valid/ready handshake.

Parameters:
- BASE_ADDR, 8'hF0, first address of the 6-byte register window; must be 8-aligned.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..8.
- PRESCALE, 1, clock cycles per timer tick, 1..255.

Ports:
- clock  in  1  system clock, the processor's clock.
- reset  in  1  asynchronous, active-high.
- MemRead  in  1  read strobe from the processor data port.
- wren  in  1  write strobe from the processor data port.
- address  in  8  data-port address (processor R2).
- data  in  8  write data (processor R1).
- q  out  8  registered read data.
- io_hit  out  1  registered; high the cycle q carries I/O data.
- sw_in  in  8  asynchronous board switches.
- led_out  out  8  LED register contents.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts the head this cycle.

Behaviour:
- Reset (async, active-high): q=0, io_hit=0, led_out=0, timer count=0, ctrl=0, prescaler=0, FIFO empty, overflow=0, tx_valid=0, tx_data=0, switch synchronizer=0.
- Decode: sel = address in [BASE_ADDR, BASE_ADDR+5]; offset = address[2:0].
- Register map (offset: access):
  - 0 LED: R/W.
  - 1 SW: R, output of a 2-flop synchronizer.
  - 2 TCNT: R; any write clears it to 0.
  - 3 TCTRL: bit0 enable R/W; bit1 wrap sticky, write 1 to clear; other bits read 0.
  - 4 TXDATA: W pushes a byte; R returns the head without popping.
  - 5 STATUS: R {2'b0, overflow, count[2:0], full, empty}; any write clears overflow.
- Writes: on a clock edge with wren=1 and sel=1. Writes outside the window are ignored.
- Reads:
  - Latency 1: on the edge where MemRead=1 and sel=1, q <= register value and io_hit <= 1.
  - Otherwise io_hit <= 0 and q holds its previous value.
  - If MemRead=1 and wren=1 in the same cycle, the write is performed and the read is suppressed (io_hit <= 0).
- Timer:
  - When enable=1, the prescaler counts 0..PRESCALE-1. On the wrap cycle TCNT increments.
  - TCNT 8'hFF -> 8'h00 sets the wrap flag.
  - enable=0 freezes both TCNT and the prescaler.
  - A write to TCNT clears both TCNT and the prescaler, and takes priority over a same-cycle tick.
  - A same-cycle wrap and write-1-to-clear of the wrap flag: set wins.
- FIFO:
  - Push when a TXDATA write occurs and the FIFO is not full. A push when full is dropped and sets overflow.
  - Pop on the edge where tx_valid=1 and tx_ready=1.
  - Simultaneous push and pop while full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH. count range 0..FIFO_DEPTH.
  - tx_data = head entry when non-empty, 0 when empty. tx_valid = !empty.
  - tx_ready is ignored when empty.
- Reset asserted mid-operation: all state returns to reset values immediately; queued FIFO contents are discarded.

Decomposition:
- Shared package mmio_pkg holds:
  - register offset constants: OFF_LED=0, OFF_SW=1, OFF_TCNT=2, OFF_TCTRL=3, OFF_TXDATA=4, OFF_STATUS=5;
  - STATUS/TCTRL bit positions.
- One sub-module io_fifo: parameterized synchronous FIFO with push, pop, full, empty, count and head. It is instantiated once.
- The timer and register file stay in mmio_responder.

Test Plan:
- Reset, then write 8'hA5 to F0 and read F0: led_out=A5 immediately after the write edge; q=A5 with io_hit=1 one cycle after the read edge.
- sw_in=8'h3C, wait 2 cycles, read F1: q=3C. Read address 8'h20: io_hit=0 and q unchanged.
- PRESCALE=1: write TCTRL=1, run 256 cycles: TCNT=0 and TCTRL read=8'h03. Write TCTRL=8'h03: wrap clears and TCNT keeps counting. Write TCNT mid-count: TCNT reads 0.
- With tx_ready=0, push 11,22,33,44,55: STATUS=8'h2 (full) | overflow bit | count=4 reads 8'h32. Raise tx_ready: tx_data sequence 11,22,33,44, then tx_valid=0 and STATUS=8'h21. Write F5: STATUS=8'h01.
- FIFO full with tx_ready=1 and a simultaneous push of 66: count stays 4, no overflow, and 66 drains last.
- Assert reset mid-drain with 3 entries queued: tx_valid=0, STATUS reads 8'h01, led_out=0.
